// File: rtl/udp_pkg.sv
// Shared encodings for the UDP port demultiplexer: result codes, header size, FSM states.
// Pure declarations; no timing or flow control of its own.
package udp_pkg;

    localparam logic [1:0] UDP_TYPE_UNSUP  = 2'b00;
    localparam logic [1:0] UDP_TYPE_VALID  = 2'b01;
    localparam logic [1:0] UDP_TYPE_LENERR = 2'b10;

    localparam int UDP_HDR_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } udp_state_e;

endpackage

// File: rtl/udp_port_match.sv
// Parallel compare of a destination port against the port table; lowest matching index wins.
// Purely combinational, zero latency; no flow control.
module udp_port_match #(
    parameter int                    N_PORTS   = 2,
    parameter logic [16*N_PORTS-1:0] PORT_LIST = {16'd10_003, 16'd10_002}
) (
    input  logic [15:0]                                 dst_port_i,
    output logic                                        match_o,
    output logic [((N_PORTS > 1) ? $clog2(N_PORTS) : 1)-1:0] idx_o
);

    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    // Scan from the top so the lowest matching entry is written last.
    always_comb begin
        match_o = 1'b0;
        idx_o   = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (dst_port_i == PORT_LIST[16*i +: 16]) begin
                match_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/udp_port_demux.sv
// UDP header parse + destination-port filter, payload packed MSB-first into WORD_BYTES words.
// Words appear the cycle after their completing byte; no backpressure, the byte stream is never stalled.
module udp_port_demux
    import udp_pkg::*;
#(
    parameter int                    N_PORTS    = 2,
    parameter logic [16*N_PORTS-1:0] PORT_LIST  = {16'd10_003, 16'd10_002},
    parameter int                    WORD_BYTES = 9
) (
    input  logic                                              CLK,
    input  logic                                              RST_N,
    input  logic [7:0]                                        IN_DATA,
    input  logic                                              IN_DATA_VLD,
    input  logic                                              UDP_EN,
    output logic [63:0]                                       UDP_HEADER,
    output logic                                              UDP_DONE,
    output logic [1:0]                                        UDP_TYPE,
    output logic [((N_PORTS > 1) ? $clog2(N_PORTS) : 1)-1:0] UDP_PORT_IDX,
    output logic [8*WORD_BYTES-1:0]                           UDP_DATA,
    output logic                                              UDP_DATA_VLD,
    output logic [WORD_BYTES-1:0]                             UDP_DATA_KEEP,
    output logic                                              UDP_DATA_LAST
);

    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int WW    = 8 * WORD_BYTES;

    function automatic logic [WORD_BYTES-1:0] keep_mask(input int n);
        logic [WORD_BYTES-1:0] m;
        m = '0;
        for (int b = 0; b < WORD_BYTES; b++) begin
            m[WORD_BYTES-1-b] = (b < n);
        end
        return m;
    endfunction

    udp_state_e          state_q, state_d;
    logic [2:0]          hcnt_q, hcnt_d;
    logic [63:0]         hdr_q, hdr_d;       // wire order: byte 0 in bits 63:56
    logic [15:0]         pcnt_q, pcnt_d;
    logic [15:0]         plen_q, plen_d;
    logic [4:0]          fill_q, fill_d;
    logic [WW-1:0]       word_q, word_d, word_nxt;
    logic [1:0]          type_q, type_d;
    logic [WW-1:0]       data_q, data_d;
    logic [WORD_BYTES-1:0] keep_q, keep_d;
    logic                dvld_q, dvld_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic [63:0]         hdr_out_q, hdr_out_d;
    logic [1:0]          type_out_q, type_out_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic                match;
    logic [IDX_W-1:0]    match_idx;
    logic [15:0]         len_w;
    logic                pay_last;

    assign len_w    = hdr_q[31:16];
    assign pay_last = ((pcnt_q + 16'd1) == plen_q);

    udp_port_match #(
        .N_PORTS   (N_PORTS),
        .PORT_LIST (PORT_LIST)
    ) u_match (
        .dst_port_i (hdr_q[47:32]),
        .match_o    (match),
        .idx_o      (match_idx)
    );

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        hdr_d      = hdr_q;
        pcnt_d     = pcnt_q;
        plen_d     = plen_q;
        fill_d     = fill_q;
        word_d     = word_q;
        type_d     = type_q;
        data_d     = data_q;
        keep_d     = keep_q;
        dvld_d     = 1'b0;
        last_d     = 1'b0;
        done_d     = 1'b0;
        hdr_out_d  = hdr_out_q;
        type_out_d = type_out_q;
        idx_d      = idx_q;
        word_nxt   = word_q;
        word_nxt[(WORD_BYTES - 1 - int'(fill_q)) * 8 +: 8] = IN_DATA;

        case (state_q)
            ST_IDLE: begin
                if (UDP_EN && IN_DATA_VLD) begin
                    hdr_d   = {IN_DATA, 56'd0};
                    hcnt_d  = 3'd1;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (!IN_DATA_VLD) begin
                    type_d  = UDP_TYPE_LENERR;
                    state_d = ST_DONE;
                end else begin
                    hdr_d[(7 - int'(hcnt_q)) * 8 +: 8] = IN_DATA;
                    hcnt_d = hcnt_q + 3'd1;
                    // Dst and length are complete by now; only the checksum byte is still arriving.
                    if (hcnt_q == 3'(UDP_HDR_BYTES - 1)) begin
                        if (match) begin
                            idx_d = match_idx;
                        end
                        if (!match) begin
                            type_d  = UDP_TYPE_UNSUP;
                            state_d = ST_DRAIN;
                        end else if (len_w < 16'(UDP_HDR_BYTES)) begin
                            type_d  = UDP_TYPE_LENERR;
                            state_d = ST_DRAIN;
                        end else if (len_w == 16'(UDP_HDR_BYTES)) begin
                            type_d  = UDP_TYPE_VALID;
                            state_d = ST_DRAIN;
                        end else begin
                            plen_d  = len_w - 16'(UDP_HDR_BYTES);
                            pcnt_d  = '0;
                            fill_d  = '0;
                            word_d  = '0;
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!IN_DATA_VLD) begin
                    if (fill_q != 5'd0) begin
                        data_d = word_q;
                        keep_d = keep_mask(int'(fill_q));
                        dvld_d = 1'b1;
                        last_d = 1'b1;
                    end
                    type_d  = UDP_TYPE_LENERR;
                    state_d = ST_DONE;
                end else begin
                    pcnt_d = pcnt_q + 16'd1;
                    // The final byte always closes a word, so an empty LAST word never exists.
                    if (pay_last || (fill_q == 5'(WORD_BYTES - 1))) begin
                        data_d = word_nxt;
                        keep_d = keep_mask(int'(fill_q) + 1);
                        dvld_d = 1'b1;
                        last_d = pay_last;
                        word_d = '0;
                        fill_d = '0;
                    end else begin
                        word_d = word_nxt;
                        fill_d = fill_q + 5'd1;
                    end
                    if (pay_last) begin
                        type_d  = UDP_TYPE_VALID;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!IN_DATA_VLD) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d     = 1'b1;
                hdr_out_d  = {hdr_q[15:0], hdr_q[31:16], hdr_q[47:32], hdr_q[63:48]};
                type_out_d = type_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            hcnt_q     <= '0;
            hdr_q      <= '0;
            pcnt_q     <= '0;
            plen_q     <= '0;
            fill_q     <= '0;
            word_q     <= '0;
            type_q     <= '0;
            data_q     <= '0;
            keep_q     <= '0;
            dvld_q     <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            hdr_out_q  <= '0;
            type_out_q <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            hdr_q      <= hdr_d;
            pcnt_q     <= pcnt_d;
            plen_q     <= plen_d;
            fill_q     <= fill_d;
            word_q     <= word_d;
            type_q     <= type_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            dvld_q     <= dvld_d;
            last_q     <= last_d;
            done_q     <= done_d;
            hdr_out_q  <= hdr_out_d;
            type_out_q <= type_out_d;
            idx_q      <= idx_d;
        end
    end

    assign UDP_HEADER    = hdr_out_q;
    assign UDP_DONE      = done_q;
    assign UDP_TYPE      = type_out_q;
    assign UDP_PORT_IDX  = idx_q;
    assign UDP_DATA      = data_q;
    assign UDP_DATA_VLD  = dvld_q;
    assign UDP_DATA_KEEP = keep_q;
    assign UDP_DATA_LAST = last_q;

endmodule
